// File: rtl/hazard_decoder_pkg.sv
// rtl/hazard_decoder_pkg.sv - shared types, opcodes and writer classification for the decode stage
package types;

  localparam int SLOT_W = 4;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_ARITH  = 4'h1;
  localparam logic [3:0] OPC_AR_IM  = 4'h2;
  localparam logic [3:0] OPC_TEST   = 4'h3;
  localparam logic [3:0] OPC_TS_IM  = 4'h4;
  localparam logic [3:0] OPC_LOAD   = 4'h5;
  localparam logic [3:0] OPC_STORE  = 4'h6;
  localparam logic [3:0] OPC_BRANCH = 4'h7;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_ALU  = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_src_e;

  typedef struct packed {
    fwd_src_e          src;
    logic [SLOT_W-1:0] slot;
  } fwd_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       is_load;
  } hist_entry_t;

  // Fields overlap by design: offs spans func/imm, rt is the low nibble of imm.
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  func;
    logic [15:0] imm;
    logic [19:0] offs;
    logic [3:0]  rt;
  } InstructionDetails;

  typedef struct packed {
    InstructionDetails dec;
    fwd_t              rs_fwd;
    fwd_t              rt_fwd;
    fwd_t              rd_fwd;
  } InstructionDetailsFwd;

  function automatic logic is_alu_writer(input logic [3:0] op);
    return op inside {OPC_ARITH, OPC_AR_IM, OPC_TEST, OPC_TS_IM};
  endfunction

endpackage

// File: rtl/hazard_decoder_if.sv
// rtl/hazard_decoder_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface hazard_decoder_if;
  import types::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instruction;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  InstructionDetailsFwd details;

  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, details
  );

  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, details
  );

endinterface

// File: rtl/hazard_decoder_history.sv
// rtl/hazard_decoder_history.sv - issued-writer history and youngest-match forwarding search
module hazard_history
  import types::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        advance,
  input  hist_entry_t push,
  input  logic [3:0]  rs,
  input  logic [3:0]  rt,
  input  logic [3:0]  rd,
  output fwd_t        rs_fwd,
  output fwd_t        rt_fwd,
  output fwd_t        rd_fwd,
  output logic        rs_load_hit,
  output logic        rt_load_hit,
  output logic        rd_load_hit
);

  // Slot 1 is the most recently issued instruction, slot FWD_DEPTH the oldest.
  hist_entry_t [FWD_DEPTH:1] hist;

  // Scan oldest to youngest so the lowest matching slot is the last one written.
  function automatic fwd_t lookup(input hist_entry_t [FWD_DEPTH:1] h, input logic [3:0] r);
    fwd_t f;
    f.src  = FWD_NONE;
    f.slot = '0;
    if (r != 4'd0) begin
      for (int s = FWD_DEPTH; s >= 1; s--) begin
        if (h[s].valid && h[s].rd == r) begin
          f.src  = h[s].is_load ? FWD_MEM : FWD_ALU;
          f.slot = SLOT_W'(s);
        end
      end
    end
    return f;
  endfunction

  // A MEM match always has slot >= 1, so LOAD_LAT = 0 never flags.
  function automatic logic load_hit(input fwd_t f);
    return (f.src == FWD_MEM) && (f.slot <= SLOT_W'(LOAD_LAT));
  endfunction

  assign rs_fwd      = lookup(hist, rs);
  assign rt_fwd      = lookup(hist, rt);
  assign rd_fwd      = lookup(hist, rd);
  assign rs_load_hit = load_hit(rs_fwd);
  assign rt_load_hit = load_hit(rt_fwd);
  assign rd_load_hit = load_hit(rd_fwd);

  // Shift one slot older on every advancing cycle; the oldest entry drops out.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      hist <= '0;
    end else if (advance) begin
      for (int s = FWD_DEPTH; s >= 2; s--) begin
        hist[s] <= hist[s-1];
      end
      hist[1] <= push;
    end
  end

endmodule

// File: rtl/hazard_decoder.sv
// rtl/hazard_decoder.sv - decode stage with forwarding select, load-use stall and output register
module hazard_decoder
  import types::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input logic             clk,
  input logic             rst_sync,
  hazard_decoder_if.slave bus
);

  InstructionDetails    dec;
  InstructionDetailsFwd details_q;
  logic                 out_valid_q;

  fwd_t        rs_fwd, rt_fwd, rd_fwd;
  logic        rs_hit, rt_hit, rd_hit;
  logic        is_writer, rt_used, rd_used;
  logic        stall, issue;
  hist_entry_t push;

  // Pure field split of the fetched word; no state involved.
  always_comb begin
    dec      = '0;
    dec.op   = bus.instruction[31:28];
    dec.rd   = bus.instruction[27:24];
    dec.rs   = bus.instruction[23:20];
    dec.func = bus.instruction[19:16];
    dec.imm  = bus.instruction[15:0];
    dec.offs = bus.instruction[19:0];
    dec.rt   = bus.instruction[3:0];
  end

  // r0 is hardwired zero, so a writer targeting it never enters the history.
  assign is_writer = (is_alu_writer(dec.op) || dec.op == OPC_LOAD) && (dec.rd != 4'd0);
  assign rt_used   = (dec.op == OPC_ARITH) || (dec.op == OPC_TEST);
  assign rd_used   = (dec.op == OPC_STORE);

  assign stall = bus.in_valid && (rs_hit || (rt_used && rt_hit) || (rd_used && rd_hit));
  assign issue = bus.out_ready && bus.in_valid && !stall && !bus.flush;

  // Flush accepts (and drops) whatever fetch presents, even while stalled.
  assign bus.in_ready = !rst_sync && (bus.flush || (bus.out_ready && !stall));

  assign push.valid   = issue && is_writer;
  assign push.rd      = dec.rd;
  assign push.is_load = (dec.op == OPC_LOAD);

  hazard_history #(
    .FWD_DEPTH(FWD_DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) u_history (
    .clk        (clk),
    .rst_sync   (rst_sync),
    .advance    (bus.out_ready),
    .push       (push),
    .rs         (dec.rs),
    .rt         (dec.rt),
    .rd         (dec.rd),
    .rs_fwd     (rs_fwd),
    .rt_fwd     (rt_fwd),
    .rd_fwd     (rd_fwd),
    .rs_load_hit(rs_hit),
    .rt_load_hit(rt_hit),
    .rd_load_hit(rd_hit)
  );

  // Output register: load on issue, bubble otherwise, hold under back-pressure, drop on flush.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      out_valid_q <= 1'b0;
      details_q   <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= issue;
      if (issue) begin
        details_q.dec    <= dec;
        details_q.rs_fwd <= rs_fwd;
        details_q.rt_fwd <= rt_fwd;
        details_q.rd_fwd <= rd_fwd;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.details   = details_q;

endmodule
